// File: rtl/row_result_writer_pkg.sv
// rtl/row_result_writer_pkg.sv - shared types and helpers for the row result writer
package row_result_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Width of a lane index; a single-lane build still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_result_writer_coord_linearizer.sv
// rtl/row_result_writer_coord_linearizer.sv - (x,y) to linear output address with range check
module coord_linearizer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int OUT_ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0]     i_x,
  input  logic [ADDR_WIDTH-1:0]     i_y,
  input  logic [ADDR_WIDTH-1:0]     i_o_size,
  output logic [OUT_ADDR_WIDTH-1:0] o_addr,
  output logic                      o_in_range
);

  // Operands are sized to the output width first so the product wraps modulo 2^OUT_ADDR_WIDTH.
  assign o_addr     = OUT_ADDR_WIDTH'(i_x) * OUT_ADDR_WIDTH'(i_o_size) + OUT_ADDR_WIDTH'(i_y);
  assign o_in_range = (i_x < i_o_size) && (i_y < i_o_size);

endmodule

// File: rtl/row_result_writer.sv
// rtl/row_result_writer.sv - serializes one router burst into output-buffer writes
module row_result_writer
  import row_result_writer_pkg::*;
#(
  parameter int ROUTER_COUNT   = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_ADDR_WIDTH = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_reg_clear,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [ROUTER_COUNT*ADDR_WIDTH-1:0] i_x,
  input  logic [ROUTER_COUNT*ADDR_WIDTH-1:0] i_y,
  input  logic [ROUTER_COUNT*DATA_WIDTH-1:0] i_data,
  input  logic [ROUTER_COUNT-1:0]            i_mask,
  input  logic [ADDR_WIDTH-1:0]              i_o_size,
  output logic                               o_wr_en,
  output logic [OUT_ADDR_WIDTH-1:0]          o_wr_addr,
  output logic [DATA_WIDTH-1:0]              o_wr_data,
  input  logic                               i_wr_ready,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [OUT_ADDR_WIDTH-1:0]          o_write_count
);

  localparam int              IDX_W    = idx_width(ROUTER_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUTER_COUNT - 1);

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [ROUTER_COUNT*ADDR_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [ROUTER_COUNT*DATA_WIDTH-1:0] data_q, data_d;
  logic [ROUTER_COUNT-1:0]           mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]             o_size_q, o_size_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;
  logic [OUT_ADDR_WIDTH-1:0]         count_q, count_d;

  logic [ADDR_WIDTH-1:0]     lane_x, lane_y;
  logic [OUT_ADDR_WIDTH-1:0] lane_addr;
  logic                      lane_in_range;
  logic                      lane_masked;
  logic                      lane_active;
  logic                      wr_en;
  logic                      advance;

  assign lane_x      = x_q[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign lane_y      = y_q[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign lane_masked = (state_q == DRAIN) && mask_q[idx_q];
  assign lane_active = lane_masked && lane_in_range;
  // A clear cancels the write in its own cycle, not just from the next one.
  assign wr_en       = lane_active && !i_reg_clear;
  assign advance     = (state_q == DRAIN) && (!lane_active || i_wr_ready);

  coord_linearizer #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .OUT_ADDR_WIDTH(OUT_ADDR_WIDTH)
  ) u_linearizer (
    .i_x       (lane_x),
    .i_y       (lane_y),
    .i_o_size  (o_size_q),
    .o_addr    (lane_addr),
    .o_in_range(lane_in_range)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    data_d   = data_q;
    mask_d   = mask_q;
    o_size_d = o_size_q;
    done_d   = 1'b0;
    err_d    = err_q;
    count_d  = count_q;

    if (i_reg_clear) begin
      state_d = IDLE;
      idx_d   = '0;
      err_d   = 1'b0;
      count_d = '0;
    end else begin
      if (wr_en && i_wr_ready && (count_q != '1)) begin
        count_d = count_q + OUT_ADDR_WIDTH'(1);
      end
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_d  = DRAIN;
            idx_d    = '0;
            x_d      = i_x;
            y_d      = i_y;
            data_d   = i_data;
            mask_d   = i_mask;
            o_size_d = i_o_size;
          end
        end
        DRAIN: begin
          if (lane_masked && !lane_in_range) begin
            err_d = 1'b1;
          end
          if (advance) begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      o_size_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      o_size_q <= o_size_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign o_ready       = (state_q == IDLE) && !i_reg_clear;
  assign o_wr_en       = wr_en;
  assign o_wr_addr     = lane_addr;
  assign o_wr_data     = data_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign o_busy        = (state_q == DRAIN);
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_write_count = count_q;

endmodule

// File: tb/tb_row_result_writer.sv
// tb/tb_row_result_writer.sv - scoreboard bench for row_result_writer
module tb_row_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] x_in = '0, y_in = '0, d_in = '0;
  logic [3:0]  mask_in = '0;
  logic [7:0]  os_in = '0;
  logic        wr_ready = 1'b1;

  logic        ready, wr_en, busy, done, err;
  logic [15:0] wr_addr, cnt;
  logic [7:0]  wr_data;
  logic        s_ready, s_wr_en, s_busy, s_done, s_err;
  logic [3:0]  s_wr_addr, s_cnt;
  logic [7:0]  s_wr_data;

  always #5 clk = ~clk;

  row_result_writer #(.ROUTER_COUNT(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .OUT_ADDR_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_reg_clear(clr), .i_valid(valid), .o_ready(ready),
    .i_x(x_in), .i_y(y_in), .i_data(d_in), .i_mask(mask_in), .i_o_size(os_in),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_ready(wr_ready),
    .o_busy(busy), .o_done(done), .o_err(err), .o_write_count(cnt)
  );

  row_result_writer #(.ROUTER_COUNT(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .OUT_ADDR_WIDTH(4)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_reg_clear(clr), .i_valid(valid), .o_ready(s_ready),
    .i_x(x_in), .i_y(y_in), .i_data(d_in), .i_mask(mask_in), .i_o_size(os_in),
    .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data), .i_wr_ready(wr_ready),
    .o_busy(s_busy), .o_done(s_done), .o_err(s_err), .o_write_count(s_cnt)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  logic err_exp = 1'b0;
  int   done_exp = 0;
  int   done_seen = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Write-ready pattern: 0 always ready, 1 random backpressure, 2 held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(0, 9) < 7);
        default: wr_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;
    wr_t         e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !clr) begin
          chk("stall_hold_en", wr_en, 1);
          chk("stall_hold_addr", wr_addr, prev_addr);
          chk("stall_hold_data", wr_data, prev_data);
        end
        if (wr_en && wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("write_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
        if (done) done_seen++;
        prev_stall = wr_en && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
      end
    end
  end

  // Reference model: every masked lane inside the o_size square is one write, in lane order.
  task automatic start_burst(input logic [3:0] m, input logic [7:0] os,
                             input logic [31:0] xs, input logic [31:0] ys, input logic [31:0] ds);
    int   a;
    logic accepted;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (xs[i*8 +: 8] < os && ys[i*8 +: 8] < os) begin
          a = int'(xs[i*8 +: 8]) * int'(os) + int'(ys[i*8 +: 8]);
          exp_q.push_back({a[15:0], ds[i*8 +: 8]});
          model_cnt++;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
    x_in = xs; y_in = ys; d_in = ds; mask_in = m; os_in = os;
    valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) begin
        accepted = 1'b1;
        break;
      end
    end
    chk("accept", accepted, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic finish_burst(input int exp_lat, input int lat0);
    int   lat;
    logic got;
    int   sat;
    lat = lat0;
    got = 1'b0;
    done_exp++;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_in_drain", busy, 1);
        chk("ready_low_in_drain", ready, 0);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (exp_lat > 0) chk("done_latency", lat, exp_lat);
    sat = (model_cnt > 15) ? 15 : model_cnt;
    chk("queue_drained", exp_q.size(), 0);
    chk("err", err, err_exp);
    chk("write_count", cnt, model_cnt);
    chk("write_count_sat", s_cnt, sat);
    chk("ready_after_done", ready, 1);
    chk("busy_after_done", busy, 0);
    chk("done_pulses", done_seen, done_exp);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic burst(input logic [3:0] m, input logic [7:0] os, input logic [31:0] xs,
                       input logic [31:0] ys, input logic [31:0] ds, input int exp_lat);
    start_burst(m, os, xs, ys, ds);
    finish_burst(exp_lat, 0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_cnt = 0;
    err_exp   = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // In-range column, full backpressure-free drain.
    burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10}, 5);

    // Lane 1 stalled for three cycles.
    start_burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10});
    @(negedge clk);
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    finish_burst(8, 4);

    // Sparse mask.
    burst(4'b0101, 8'd5, {8'd9, 8'd4, 8'd9, 8'd1}, {8'd9, 8'd4, 8'd9, 8'd2},
          {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 5);

    // Out-of-range lane 2, then err must persist across a clean burst.
    burst(4'hF, 8'd3, {8'd2, 8'd3, 8'd1, 8'd0}, {8'd2, 8'd0, 8'd1, 8'd0},
          {8'h44, 8'h33, 8'h22, 8'h11}, 5);
    burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10}, 5);

    // Clear mid-burst while lane 2 is stalled.
    start_burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10});
    @(negedge clk);
    @(negedge clk);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    chk("clear_no_write", wr_en, 0);
    chk("clear_no_done", done, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    rdy_mode = 0;
    model_clear();
    @(negedge clk);
    chk("clear_busy", busy, 0);
    chk("clear_ready", ready, 1);
    chk("clear_count", cnt, 0);
    chk("clear_count_sat", s_cnt, 0);
    chk("clear_err", err, 0);
    chk("clear_done", done, 0);
    chk("clear_done_pulses", done_seen, done_exp);
    @(posedge clk);
    #1;

    // Randomized bursts.
    for (int b = 0; b < 30; b++) begin
      logic [7:0]  os;
      logic [31:0] xs, ys, ds;
      int          r, lim;
      rdy_mode = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      os = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 8));
      lim = (os > 8'd250) ? 255 : int'(os) + 1;
      for (int i = 0; i < 4; i++) begin
        xs[i*8 +: 8] = 8'($urandom_range(0, lim));
        ys[i*8 +: 8] = 8'($urandom_range(0, lim));
        ds[i*8 +: 8] = 8'($urandom);
      end
      burst(4'($urandom), os, xs, ys, ds, (rdy_mode == 0) ? 5 : 0);
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        @(negedge clk);
        chk("idle_clear_err", err, 0);
        chk("idle_clear_count", cnt, 0);
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;

    // Saturation of the narrow counter, then async reset mid-burst.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    for (int b = 0; b < 5; b++) begin
      burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10}, 5);
    end
    burst(4'hF, 8'd0, 32'h0, 32'h0, 32'h01020304, 5);
    start_burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10});
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_count_sat", s_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    burst(4'hF, 8'd4, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd13, 8'd12, 8'd11, 8'd10}, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
